mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; consumes the EX/MEM register produced by the execute stage.
//  Performs aligned data-memory loads/stores over a req/ack handshake.
//  Aligns store data and builds byte strobes; sign/zero-extends load data.
//  Stalls the pipeline while an access is outstanding; drives the MEM/WB pipeline register
//  and the MEM-stage forwarding value.
// PARAMETERS
//  DATA_BITS  32  data/address width
//  REG_BITS   5   register-index width
//  TYPE_BITS  3   access type width (RV32 func3 encoding)
// PORTS
//  clk            in   1          clock (rising edge)
//  rst            in   1          reset: asynchronous, active-high
//  datatype_i     in   TYPE_BITS  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  aluout_i       in   DATA_BITS  ALU result / effective address
//  dm_data_i      in   DATA_BITS  store data (rs2)
//  pc2reg_i       in   DATA_BITS  pc+4 / pc+imm link value
//  rd_addr_i      in   REG_BITS   destination register
//  reg_wr_i       in   1          register write enable
//  rd_src_i       in   1          1: result is pc2reg_i; 0: result is aluout_i
//  dm2reg_i       in   1          writeback selects load data
//  dm_rd_i        in   1          load
//  dm_wr_i        in   1          store
//  memwb_en_i     in   1          0: hold the MEM/WB register (downstream stall)
//  dm_req_o       out  1          bus request (registered)
//  dm_we_o        out  1          1 store, 0 load
//  dm_addr_o      out  DATA_BITS  word address: {aluout[31:2],2'b00}
//  dm_wstrb_o     out  4          byte strobes (store only; 4'h0 on load)
//  dm_wdata_o     out  DATA_BITS  lane-shifted store data
//  dm_ack_i       in   1          access complete; dm_rdata_i valid same cycle
//  dm_rdata_i     in   DATA_BITS  read word
//  stall_o        out  1          hold PC/IF/ID/EX/MEM registers
//  misalign_o     out  1          one-cycle pulse: misaligned access dropped
//  mem_rd_data_o  out  DATA_BITS  forwarding value: rd_src_i ? pc2reg_i : aluout_i (combinational)
//  wb_rd_data_o   out  DATA_BITS  MEM/WB: selected non-load result
//  wb_ld_data_o   out  DATA_BITS  MEM/WB: extended load data
//  wb_rd_addr_o   out  REG_BITS   MEM/WB destination register
//  wb_reg_wr_o    out  1          MEM/WB write enable
//  wb_dm2reg_o    out  1          MEM/WB load-select
// BEHAVIOUR
//  Reset: every registered output is 0 (dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, dm_wdata_o, all wb_*_o, misalign_o); FSM=IDLE.
//  FSM states IDLE / REQ / DONE:
//   IDLE: if memop=(dm_rd_i|dm_wr_i) and aligned -> REQ; latch addr/we/wstrb/wdata; set dm_req_o=1.
//   IDLE: if memop and misaligned -> stay IDLE; misalign_o=1 for 1 cycle; no bus access.
//     The instruction passes as a non-load with wb_reg_wr_o=0.
//   REQ: dm_req_o and all bus outputs held stable until dm_ack_i.
//     On ack: capture extended rdata; dm_req_o<=0; -> DONE.
//   DONE: -> IDLE unconditionally.
//  stall_o = (IDLE & memop & aligned) | REQ. stall_o is 0 in DONE so EX/MEM advances.
//  MEM/WB update: on edges with stall_o=0 and memwb_en_i=1; otherwise hold.
//  Bubble: MEM/WB loads reg_wr=0 on an edge where stall_o=1 and memwb_en_i=1.
//  Memory op latency: 3 cycles minimum (ack in first REQ cycle); +1 per wait cycle.
//  Non-memory op latency: 1 cycle.
//  Misaligned: H with addr[0]=1; W with addr[1:0]!=0. B is always aligned.
//  Strobes: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'hF.
//  wdata = replicated byte/half/word (B: {4{d[7:0]}}, H: {2{d[15:0]}}).
//  Load: select byte/half by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU; W as-is.
//  Reset mid-access: dm_req_o drops asynchronously; access abandoned; a late ack in IDLE is ignored.
//  memwb_en_i=0 in DONE: load data stays in its capture register until the MEM/WB update.
//  dm_rd_i & dm_wr_i both set is illegal; treat as store.
// TESTING
//  LW @0x100, rdata=0xDEADBEEF, ack in 1st REQ cycle -> stall 2 cycles; wb_ld_data_o=0xDEADBEEF, dm_wstrb_o=0.
//  LB @0x103, rdata=0x80xxxxxx -> wb_ld_data_o=0xFFFFFF80; LBU same -> 0x00000080.
//  SH @0x102, data=0x1234ABCD -> dm_wstrb_o=4'b1100, dm_wdata_o=0xABCDABCD, dm_we_o=1.
//  LW @0x101 -> misalign_o pulse, no dm_req_o, wb_reg_wr_o=0, no stall.
//  Ack delayed 5 cycles -> dm_addr_o/dm_req_o stable throughout; stall_o high 6 cycles.
//  rst asserted in REQ -> dm_req_o=0 immediately; following ADD completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
//
// Purpose: groups the data-memory handshake so the MEM stage and the memory
// model/controller connect through one port.
// Signals:
//   req    MEM stage -> memory   access request (held until ack)
//   we     MEM stage -> memory   1 store, 0 load
//   addr   MEM stage -> memory   word address (low two bits zero)
//   wstrb  MEM stage -> memory   byte strobes (zero on loads)
//   wdata  MEM stage -> memory   lane-replicated store data
//   ack    memory -> MEM stage   access complete; rdata valid in the same cycle
//   rdata  memory -> MEM stage   read word
interface mem_stage_if #(
   parameter int DATA_BITS = 32
);
   logic                 req;
   logic                 we;
   logic [DATA_BITS-1:0] addr;
   logic [3:0]           wstrb;
   logic [DATA_BITS-1:0] wdata;
   logic                 ack;
   logic [DATA_BITS-1:0] rdata;

   modport master (
      output req, we, addr, wstrb, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wstrb, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ack data-memory port
//
// Purpose: takes the EX/MEM register contents, performs aligned loads/stores
// over the dm bus, stalls the pipeline while an access is outstanding, and
// drives the MEM/WB register plus the MEM-stage forwarding value.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   datatype_i               func3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   aluout_i                 ALU result / effective address
//   dm_data_i                store data (rs2)
//   pc2reg_i                 link value (pc+4 / pc+imm)
//   rd_addr_i, reg_wr_i      destination register and its write enable
//   rd_src_i                 1 selects pc2reg_i as the non-load result
//   dm2reg_i                 writeback selects load data
//   dm_rd_i, dm_wr_i         load / store (both set is treated as store)
//   memwb_en_i               0 holds the MEM/WB register
//   dm                       data-memory bus (master side)
//   stall_o                  holds PC/IF/ID/EX/MEM registers
//   misalign_o               one-cycle pulse when a misaligned access is dropped
//   mem_rd_data_o            combinational forwarding value
//   wb_*_o                   MEM/WB register outputs
module mem_stage #(
   parameter int DATA_BITS = 32,
   parameter int REG_BITS  = 5,
   parameter int TYPE_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TYPE_BITS-1:0] datatype_i,
   input  logic [DATA_BITS-1:0] aluout_i,
   input  logic [DATA_BITS-1:0] dm_data_i,
   input  logic [DATA_BITS-1:0] pc2reg_i,
   input  logic [REG_BITS-1:0]  rd_addr_i,
   input  logic                 reg_wr_i,
   input  logic                 rd_src_i,
   input  logic                 dm2reg_i,
   input  logic                 dm_rd_i,
   input  logic                 dm_wr_i,
   input  logic                 memwb_en_i,
   mem_stage_if.master          dm,
   output logic                 stall_o,
   output logic                 misalign_o,
   output logic [DATA_BITS-1:0] mem_rd_data_o,
   output logic [DATA_BITS-1:0] wb_rd_data_o,
   output logic [DATA_BITS-1:0] wb_ld_data_o,
   output logic [REG_BITS-1:0]  wb_rd_addr_o,
   output logic                 wb_reg_wr_o,
   output logic                 wb_dm2reg_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                 memop;
   logic                 misaligned;
   logic [1:0]           size;
   logic                 start;      // launch a bus access this edge
   logic                 drop;       // misaligned access discarded this cycle
   logic                 cap;        // ack seen: capture load data this edge
   logic [3:0]           wstrb_c;
   logic [DATA_BITS-1:0] wdata_c;
   logic [DATA_BITS-1:0] shifted;
   logic [DATA_BITS-1:0] ld_ext;
   logic [DATA_BITS-1:0] ld_cap_q;   // load result waits here until MEM/WB updates
   logic [1:0]           off_q;      // byte offset and type of the access in flight
   logic [TYPE_BITS-1:0] type_q;

   assign memop         = dm_rd_i | dm_wr_i;
   assign size          = datatype_i[1:0];
   // size 11 is not a legal func3; it is handled like a word access
   assign misaligned    = ((size == 2'b01) && aluout_i[0]) ||
                          (size[1] && (aluout_i[1:0] != 2'b00));
   assign mem_rd_data_o = rd_src_i ? pc2reg_i : aluout_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      start   = 1'b0;
      drop    = 1'b0;
      cap     = 1'b0;
      case (state_q)
         IDLE: begin
            if (memop) begin
               if (misaligned) begin
                  drop = 1'b1;
               end else begin
                  start   = 1'b1;
                  stall_o = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            stall_o = 1'b1;
            if (dm.ack) begin
               cap     = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (size)
         2'b00:   wstrb_c = 4'b0001 << aluout_i[1:0];
         2'b01:   wstrb_c = 4'b0011 << aluout_i[1:0];
         default: wstrb_c = 4'hF;
      endcase
   end

   always_comb begin
      case (size)
         2'b00:   wdata_c = {4{dm_data_i[7:0]}};
         2'b01:   wdata_c = {2{dm_data_i[15:0]}};
         default: wdata_c = dm_data_i;
      endcase
   end

   // Move the addressed lane down to bit 0; func3[2] set means zero-extend.
   // Word accesses always have offset 0, so the shifted word is the raw word.
   assign shifted = dm.rdata >> {off_q, 3'b000};

   always_comb begin
      case (type_q[1:0])
         2'b00:   ld_ext = {{24{~type_q[2] & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_ext = {{16{~type_q[2] & shifted[15]}}, shifted[15:0]};
         default: ld_ext = shifted;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm.req       <= 1'b0;
         dm.we        <= 1'b0;
         dm.addr      <= '0;
         dm.wstrb     <= 4'h0;
         dm.wdata     <= '0;
         misalign_o   <= 1'b0;
         off_q        <= 2'b00;
         type_q       <= '0;
         ld_cap_q     <= '0;
         wb_rd_data_o <= '0;
         wb_ld_data_o <= '0;
         wb_rd_addr_o <= '0;
         wb_reg_wr_o  <= 1'b0;
         wb_dm2reg_o  <= 1'b0;
      end else begin
         misalign_o <= drop & memwb_en_i;

         // Bus outputs are only loaded at launch, so they stay stable through REQ.
         if (start) begin
            dm.req   <= 1'b1;
            dm.we    <= dm_wr_i;
            dm.addr  <= {aluout_i[DATA_BITS-1:2], 2'b00};
            dm.wstrb <= dm_wr_i ? wstrb_c : 4'h0;
            dm.wdata <= dm_wr_i ? wdata_c : '0;
            off_q    <= aluout_i[1:0];
            type_q   <= datatype_i;
         end

         if (cap) begin
            dm.req   <= 1'b0;
            ld_cap_q <= ld_ext;
         end

         if (memwb_en_i) begin
            if (stall_o) begin
               wb_reg_wr_o <= 1'b0;      // bubble while the access is outstanding
            end else begin
               wb_rd_data_o <= mem_rd_data_o;
               wb_ld_data_o <= ld_cap_q;
               wb_rd_addr_o <= rd_addr_i;
               wb_reg_wr_o  <= reg_wr_i & ~drop;
               wb_dm2reg_o  <= dm2reg_i & ~drop;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking testbench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  datatype;
   logic [31:0] aluout, dm_data, pc2reg;
   logic [4:0]  rd_addr;
   logic        reg_wr, rd_src, dm2reg, dm_rd, dm_wr, memwb_en;
   logic        stall, misalign;
   logic [31:0] mem_rd_data, wb_rd_data, wb_ld_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_reg_wr, wb_dm2reg;

   int          ack_wait;
   logic        force_ack;
   logic [31:0] mem_rdata;
   int          req_age;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage_if #(.DATA_BITS(32)) dm ();

   // Memory model: ack in the ack_wait-th cycle of a request.
   assign dm.ack   = force_ack | (dm.req && (req_age == ack_wait - 1));
   assign dm.rdata = mem_rdata;

   always @(posedge clk) begin
      if (!dm.req || dm.ack) req_age <= 0;
      else                   req_age <= req_age + 1;
   end

   mem_stage #(.DATA_BITS(32), .REG_BITS(5), .TYPE_BITS(3)) dut (
      .clk(clk), .rst(rst),
      .datatype_i(datatype), .aluout_i(aluout), .dm_data_i(dm_data), .pc2reg_i(pc2reg),
      .rd_addr_i(rd_addr), .reg_wr_i(reg_wr), .rd_src_i(rd_src), .dm2reg_i(dm2reg),
      .dm_rd_i(dm_rd), .dm_wr_i(dm_wr), .memwb_en_i(memwb_en),
      .dm(dm),
      .stall_o(stall), .misalign_o(misalign), .mem_rd_data_o(mem_rd_data),
      .wb_rd_data_o(wb_rd_data), .wb_ld_data_o(wb_ld_data), .wb_rd_addr_o(wb_rd_addr),
      .wb_reg_wr_o(wb_reg_wr), .wb_dm2reg_o(wb_dm2reg)
   );

   typedef struct {
      string       name;
      logic [2:0]  dtype;
      logic        rd, wr;
      logic [31:0] addr, sdata, pc;
      logic        rd_src;
      logic [31:0] rdata;
      int          wait_n;
      logic [4:0]  rdst;
      logic        reg_wr, dm2reg;
      logic        mis;
      logic [3:0]  wstrb;
      logic [31:0] wdata, ld;
   } vec_t;

   typedef struct {
      logic [31:0] rd_data, ld;
      logic [4:0]  rdst;
      logic        reg_wr, dm2reg, chk_ld, mis;
   } wb_exp_t;

   wb_exp_t sb[$];
   vec_t    vec[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] t, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rdst, input logic rw, input logic d2r);
      datatype = t; dm_rd = r; dm_wr = w; aluout = a; dm_data = d;
      rd_addr = rdst; reg_wr = rw; dm2reg = d2r; rd_src = 1'b0; pc2reg = 32'h0;
   endtask

   task automatic run_op(input vec_t v);
      wb_exp_t     e;
      int          stall_cnt, req_cnt, exp_stall, exp_req;
      logic [31:0] a0, d0;
      logic [3:0]  s0;
      logic        w0, moved, done, access;
      drive(v.dtype, v.rd, v.wr, v.addr, v.sdata, v.rdst, v.reg_wr, v.dm2reg);
      pc2reg = v.pc; rd_src = v.rd_src;
      memwb_en = 1'b1; ack_wait = v.wait_n; mem_rdata = v.rdata;
      access   = (v.rd | v.wr) & ~v.mis;
      e.rd_data = v.rd_src ? v.pc : v.addr;
      e.ld      = v.ld;
      e.rdst    = v.rdst;
      e.reg_wr  = v.mis ? 1'b0 : v.reg_wr;
      e.dm2reg  = v.mis ? 1'b0 : v.dm2reg;
      e.chk_ld  = access & v.rd & ~v.wr;
      e.mis     = v.mis;
      sb.push_back(e);
      #1;
      chk({v.name, ".fwd"}, mem_rd_data, e.rd_data);
      stall_cnt = 0; req_cnt = 0; moved = 1'b0; done = 1'b0;
      a0 = '0; d0 = '0; s0 = '0; w0 = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (dm.req) begin
            if (req_cnt == 0) begin
               a0 = dm.addr; d0 = dm.wdata; s0 = dm.wstrb; w0 = dm.we;
            end else if (dm.addr !== a0 || dm.wdata !== d0 || dm.wstrb !== s0 || dm.we !== w0) begin
               moved = 1'b1;
            end
            req_cnt++;
         end
         if (stall) stall_cnt++;
         else       done = 1'b1;
         tick();
      end
      chk({v.name, ".finished"}, 32'(done), 32'd1);
      exp_stall = access ? v.wait_n + 1 : 0;
      exp_req   = access ? v.wait_n : 0;
      chk({v.name, ".stall_cycles"}, stall_cnt, exp_stall);
      chk({v.name, ".req_cycles"}, req_cnt, exp_req);
      if (access) begin
         chk({v.name, ".addr"}, a0, {v.addr[31:2], 2'b00});
         chk({v.name, ".we"}, 32'(w0), 32'(v.wr));
         chk({v.name, ".wstrb"}, 32'(s0), 32'(v.wstrb));
         chk({v.name, ".bus_stable"}, 32'(moved), 32'd0);
         if (v.wr) chk({v.name, ".wdata"}, d0, v.wdata);
      end
      chk({v.name, ".req_low_after"}, 32'(dm.req), 32'd0);
      e = sb.pop_front();
      chk({v.name, ".wb_rd_data"}, wb_rd_data, e.rd_data);
      chk({v.name, ".wb_rd_addr"}, 32'(wb_rd_addr), 32'(e.rdst));
      chk({v.name, ".wb_reg_wr"}, 32'(wb_reg_wr), 32'(e.reg_wr));
      chk({v.name, ".wb_dm2reg"}, 32'(wb_dm2reg), 32'(e.dm2reg));
      chk({v.name, ".misalign"}, 32'(misalign), 32'(e.mis));
      if (e.chk_ld) chk({v.name, ".wb_ld_data"}, wb_ld_data, e.ld);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        name      type    rd wr addr         sdata         pc          src rdata         wt rd    rw d2r mis strb   wdata         ld
      vec[0]  = '{"lw_100",  3'b010, 1, 0, 32'h100, 32'h0,        32'h0,    0, 32'hDEADBEEF, 1, 5'd1, 1, 1, 0, 4'h0, 32'h0,        32'hDEADBEEF};
      vec[1]  = '{"lb_103",  3'b000, 1, 0, 32'h103, 32'h0,        32'h0,    0, 32'h80123456, 1, 5'd2, 1, 1, 0, 4'h0, 32'h0,        32'hFFFFFF80};
      vec[2]  = '{"lbu_103", 3'b100, 1, 0, 32'h103, 32'h0,        32'h0,    0, 32'h80123456, 1, 5'd2, 1, 1, 0, 4'h0, 32'h0,        32'h00000080};
      vec[3]  = '{"sh_102",  3'b001, 0, 1, 32'h102, 32'h1234ABCD, 32'h0,    0, 32'h0,        1, 5'd0, 0, 0, 0, 4'hC, 32'hABCDABCD, 32'h0};
      vec[4]  = '{"lw_101",  3'b010, 1, 0, 32'h101, 32'h0,        32'h0,    0, 32'h0,        1, 5'd3, 1, 1, 1, 4'h0, 32'h0,        32'h0};
      vec[5]  = '{"lw_wait", 3'b010, 1, 0, 32'h200, 32'h0,        32'h0,    0, 32'h13579BDF, 5, 5'd4, 1, 1, 0, 4'h0, 32'h0,        32'h13579BDF};
      vec[6]  = '{"lh_106",  3'b001, 1, 0, 32'h106, 32'h0,        32'h0,    0, 32'h80017FFF, 1, 5'd7, 1, 1, 0, 4'h0, 32'h0,        32'hFFFF8001};
      vec[7]  = '{"lhu_104", 3'b101, 1, 0, 32'h104, 32'h0,        32'h0,    0, 32'h1234F00D, 2, 5'd8, 1, 1, 0, 4'h0, 32'h0,        32'h0000F00D};
      vec[8]  = '{"sb_101",  3'b000, 0, 1, 32'h101, 32'h000000A5, 32'h0,    0, 32'h0,        2, 5'd0, 0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0};
      vec[9]  = '{"sw_10c",  3'b010, 0, 1, 32'h10C, 32'hCAFEF00D, 32'h0,    0, 32'h0,        3, 5'd0, 0, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0};
      vec[10] = '{"sh_101",  3'b001, 0, 1, 32'h101, 32'h5555AAAA, 32'h0,    0, 32'h0,        1, 5'd0, 0, 0, 1, 4'h0, 32'h0,        32'h0};
      vec[11] = '{"add",     3'b000, 0, 0, 32'h55,  32'h0,        32'h0,    0, 32'h0,        1, 5'd5, 1, 0, 0, 4'h0, 32'h0,        32'h0};
      vec[12] = '{"jal",     3'b000, 0, 0, 32'h8,   32'h0,        32'h1004, 1, 32'h0,        1, 5'd1, 1, 0, 0, 4'h0, 32'h0,        32'h0};
      vec[13] = '{"rdwr_sb", 3'b000, 1, 1, 32'h102, 32'h00000077, 32'h0,    0, 32'h0,        1, 5'd0, 0, 0, 0, 4'h4, 32'h77777777, 32'h0};
      vec[14] = '{"lb_101",  3'b000, 1, 0, 32'h101, 32'h0,        32'h0,    0, 32'h0000FE00, 1, 5'd9, 1, 1, 0, 4'h0, 32'h0,        32'hFFFFFFFE};
      vec[15] = '{"lb_100",  3'b000, 1, 0, 32'h100, 32'h0,        32'h0,    0, 32'h0000007F, 4, 5'd10, 1, 1, 0, 4'h0, 32'h0,       32'h0000007F};

      // reset state
      rst = 1'b1; force_ack = 1'b0; ack_wait = 1; mem_rdata = '0; memwb_en = 1'b1;
      drive(3'b000, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
      tick();
      tick();
      chk("rst.req", 32'(dm.req), 32'd0);
      chk("rst.we", 32'(dm.we), 32'd0);
      chk("rst.addr", dm.addr, 32'h0);
      chk("rst.wstrb", 32'(dm.wstrb), 32'd0);
      chk("rst.wdata", dm.wdata, 32'h0);
      chk("rst.misalign", 32'(misalign), 32'd0);
      chk("rst.wb", {wb_rd_data[15:0], 4'h0, 1'b0, wb_rd_addr, wb_reg_wr, wb_dm2reg, 4'h0}, 32'h0);
      chk("rst.wb_ld", wb_ld_data, 32'h0);
      chk("rst.stall", 32'(stall), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) run_op(vec[i]);

      // MEM/WB hold: load completes with memwb_en low, data waits in capture register
      run_op(vec[11]);
      drive(3'b010, 1, 0, 32'h300, 32'h0, 5'd12, 1, 1);
      memwb_en = 1'b0; ack_wait = 1; mem_rdata = 32'hA5A50F0F;
      tick();
      tick();
      tick();
      chk("hold.wb_reg_wr", 32'(wb_reg_wr), 32'd1);
      chk("hold.wb_rd_addr", 32'(wb_rd_addr), 32'd5);
      drive(3'b000, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
      memwb_en = 1'b1;
      tick();
      chk("hold.wb_ld_data", wb_ld_data, 32'hA5A50F0F);
      chk("hold.wb_reg_wr_nop", 32'(wb_reg_wr), 32'd0);

      // bubble: first stalled edge clears the MEM/WB write enable
      run_op(vec[11]);
      drive(3'b010, 1, 0, 32'h304, 32'h0, 5'd13, 1, 1);
      ack_wait = 1; mem_rdata = 32'h0BADCAFE;
      tick();
      chk("bubble.wb_reg_wr", 32'(wb_reg_wr), 32'd0);
      chk("bubble.stall", 32'(stall), 32'd1);
      tick();
      chk("bubble.done_stall", 32'(stall), 32'd0);
      tick();
      chk("bubble.wb_ld_data", wb_ld_data, 32'h0BADCAFE);
      chk("bubble.wb_rd_addr", 32'(wb_rd_addr), 32'd13);
      chk("bubble.wb_reg_wr_load", 32'(wb_reg_wr), 32'd1);
      drive(3'b000, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
      tick();

      // reset during REQ, then a late ack while idle
      drive(3'b010, 1, 0, 32'h400, 32'h0, 5'd14, 1, 1);
      ack_wait = 1000;
      tick();
      tick();
      chk("rstreq.req_before", 32'(dm.req), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstreq.req_async", 32'(dm.req), 32'd0);
      #1;
      rst = 1'b0;
      drive(3'b000, 0, 0, 32'h77, 32'h0, 5'd6, 1, 0);
      ack_wait = 1; force_ack = 1'b1;
      #1;
      chk("rstreq.add_stall", 32'(stall), 32'd0);
      tick();
      chk("rstreq.add_wb_rd_data", wb_rd_data, 32'h77);
      chk("rstreq.add_wb_reg_wr", 32'(wb_reg_wr), 32'd1);
      chk("rstreq.late_ack_req", 32'(dm.req), 32'd0);
      chk("rstreq.late_ack_stall", 32'(stall), 32'd0);
      force_ack = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
